safe_sequencer: RTL and testbench

Keypad-entry sequencer for the safe. It sits between the keypad scanner's decoded key stream and the lock/indicator outputs, and replaces the flat compare in the current safe control path. It collects digit sequences, checks them against a stored 4-digit code, and counts failed attempts into a timed lockout. While the safe is open it also allows the stored code to be reprogrammed.

---
 rtl/safe_sequencer_if.sv | 28 ++
 rtl/safe_sequencer.sv | 176 +++++++++++++++++
 tb/tb_safe_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/safe_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : safe_sequencer_if
// Brief    : keypad stream and lock/indicator bundle for safe_sequencer
// Revision : 1.0
// ============================================================================
interface safe_sequencer_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       prog_req;
   logic       key_ready;
   logic       lock;
   logic       green;
   logic       blue;
   logic       lockout;
   logic [1:0] fail_count;

   modport master (
      output key_valid, key_code, prog_req,
      input  key_ready, lock, green, blue, lockout, fail_count
   );

   modport slave (
      input  key_valid, key_code, prog_req,
      output key_ready, lock, green, blue, lockout, fail_count
   );
endinterface
`default_nettype wire

// File: rtl/safe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : safe_sequencer
// Brief    : keypad code sequencer with failed-attempt lockout and reprogramming
// Revision : 1.0
// ============================================================================
module safe_sequencer #(
   parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
   parameter int          MAX_FAILS      = 3,
   parameter int          ENTRY_TIMEOUT  = 4096,
   parameter int          OPEN_TIMEOUT   = 8192,
   parameter int          LOCKOUT_CYCLES = 16384
) (
   input  logic            clk,
   input  logic            rst_n,
   safe_sequencer_if.slave bus
);
   localparam int c_TMAX_EO = (ENTRY_TIMEOUT > OPEN_TIMEOUT) ? ENTRY_TIMEOUT : OPEN_TIMEOUT;
   localparam int c_TMAX    = (c_TMAX_EO > LOCKOUT_CYCLES) ? c_TMAX_EO : LOCKOUT_CYCLES;
   localparam int c_TW      = $clog2(c_TMAX) + 1;

   // Expiry fires on the edge that completes the programmed number of idle cycles.
   localparam logic [c_TW-1:0] c_ENTRY_LAST = c_TW'(ENTRY_TIMEOUT - 1);
   localparam logic [c_TW-1:0] c_OPEN_LAST  = c_TW'(OPEN_TIMEOUT - 1);
   localparam logic [c_TW-1:0] c_LOCK_LAST  = c_TW'(LOCKOUT_CYCLES - 1);

   localparam logic [1:0] c_FAIL_MAX  = 2'(MAX_FAILS);
   localparam logic [1:0] c_FAIL_LAST = 2'(MAX_FAILS - 1);
   localparam logic [3:0] c_KEY_CLEAR = 4'hA;
   localparam logic [3:0] c_KEY_ENTER = 4'hB;

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_ENTRY   = 3'd1;
   localparam logic [2:0] c_ST_CHECK   = 3'd2;
   localparam logic [2:0] c_ST_OPEN    = 3'd3;
   localparam logic [2:0] c_ST_PROG    = 3'd4;
   localparam logic [2:0] c_ST_LOCKOUT = 3'd5;

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [15:0]     r_buf;
   logic [2:0]      r_cnt;
   logic [15:0]     r_code;
   logic [1:0]      r_fail;
   logic [c_TW-1:0] r_timer;

   logic w_ready, w_lock, w_green, w_blue, w_lockout;
   logic w_acc, w_is_digit, w_is_clear, w_is_enter;
   logic w_expire, w_timed, w_match, w_shift, w_clear_buf;

   assign w_acc      = bus.key_valid & w_ready;
   assign w_is_digit = (bus.key_code <= 4'd9);
   assign w_is_clear = (bus.key_code == c_KEY_CLEAR);
   assign w_is_enter = (bus.key_code == c_KEY_ENTER);
   assign w_match    = (r_cnt == 3'd4) && (r_buf == r_code);

   always_comb begin
      w_expire = 1'b0;
      w_timed  = 1'b1;
      case (r_state)
         c_ST_ENTRY:   w_expire = (r_timer == c_ENTRY_LAST);
         c_ST_OPEN,
         c_ST_PROG:    w_expire = (r_timer == c_OPEN_LAST);
         c_ST_LOCKOUT: w_expire = (r_timer == c_LOCK_LAST);
         default:      w_timed  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_acc && w_is_digit) w_next = c_ST_ENTRY;
         end
         c_ST_ENTRY: begin
            if (w_acc) begin
               if (w_is_clear)      w_next = c_ST_IDLE;
               else if (w_is_enter) w_next = c_ST_CHECK;
            end else if (w_expire) begin
               w_next = c_ST_IDLE;
            end
         end
         c_ST_CHECK: begin
            if (w_match)                    w_next = c_ST_OPEN;
            else if (r_fail == c_FAIL_LAST) w_next = c_ST_LOCKOUT;
            else                            w_next = c_ST_IDLE;
         end
         c_ST_OPEN: begin
            if (w_acc) begin
               if (w_is_enter)                      w_next = c_ST_IDLE;
               else if (w_is_clear && bus.prog_req) w_next = c_ST_PROG;
            end else if (w_expire) begin
               w_next = c_ST_IDLE;
            end
         end
         c_ST_PROG: begin
            if (w_acc) begin
               if (w_is_enter) w_next = c_ST_OPEN;
            end else if (w_expire) begin
               w_next = c_ST_IDLE;
            end
         end
         c_ST_LOCKOUT: begin
            if (w_expire) w_next = c_ST_IDLE;
         end
         default: w_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready   = 1'b1;
      w_lock    = 1'b1;
      w_green   = 1'b0;
      w_blue    = 1'b0;
      w_lockout = 1'b0;
      case (r_state)
         c_ST_ENTRY:   w_blue = 1'b1;
         c_ST_CHECK:   w_ready = 1'b0;
         c_ST_OPEN:    begin w_lock = 1'b0; w_green = 1'b1; end
         c_ST_PROG:    begin w_lock = 1'b0; w_blue  = 1'b1; end
         c_ST_LOCKOUT: begin w_ready = 1'b0; w_lockout = 1'b1; end
         default:      w_ready = 1'b1;
      endcase
   end

   // Buffer survives only while collecting digits or awaiting the check.
   assign w_clear_buf = ((w_next != c_ST_ENTRY) && (w_next != c_ST_PROG) && (w_next != c_ST_CHECK))
                      || (r_state == c_ST_OPEN)
                      || ((r_state == c_ST_PROG) && w_acc && w_is_clear);
   assign w_shift     = w_acc && w_is_digit && (r_cnt < 3'd4)
                      && ((r_state == c_ST_IDLE) || (r_state == c_ST_ENTRY) || (r_state == c_ST_PROG));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf   <= '0;
         r_cnt   <= '0;
         r_code  <= DEFAULT_CODE;
         r_fail  <= '0;
         r_timer <= '0;
      end else begin
         if (w_acc || (w_next != r_state) || !w_timed) r_timer <= '0;
         else                                          r_timer <= r_timer + c_TW'(1);

         if (w_clear_buf) begin
            r_buf <= '0;
            r_cnt <= '0;
         end else if (w_shift) begin
            r_buf <= {r_buf[11:0], bus.key_code};
            r_cnt <= r_cnt + 3'd1;
         end

         if ((r_state == c_ST_PROG) && w_acc && w_is_enter && (r_cnt == 3'd4))
            r_code <= r_buf;

         if (r_state == c_ST_CHECK) begin
            if (w_match)                  r_fail <= '0;
            else if (r_fail != c_FAIL_MAX) r_fail <= r_fail + 2'd1;
         end else if ((r_state == c_ST_LOCKOUT) && w_expire) begin
            r_fail <= '0;
         end
      end
   end

   assign bus.key_ready  = w_ready;
   assign bus.lock       = w_lock;
   assign bus.green      = w_green;
   assign bus.blue       = w_blue;
   assign bus.lockout    = w_lockout;
   assign bus.fail_count = r_fail;
endmodule
`default_nettype wire

// File: tb/tb_safe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_sequencer
// Brief    : randomized scoreboard bench for safe_sequencer against a keypad-level model
// Revision : 1.0
// ============================================================================
module tb_safe_sequencer;
   localparam int ETO  = 16;
   localparam int OTO  = 32;
   localparam int LCK  = 64;
   localparam int MAXF = 3;

   typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_PROG, M_LOCKED} mode_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   safe_sequencer_if bus_if();

   safe_sequencer #(
      .DEFAULT_CODE   (16'h1234),
      .MAX_FAILS      (MAXF),
      .ENTRY_TIMEOUT  (ETO),
      .OPEN_TIMEOUT   (OTO),
      .LOCKOUT_CYCLES (LCK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Reference model: what the safe should look like after each clock edge.
   mode_t m_mode = M_IDLE;
   int    m_digits[$];
   int    m_code[4] = '{1, 2, 3, 4};
   int    m_fails = 0;
   int    m_quiet = 0;
   logic [6:0] exp_q[$];

   function automatic bit code_matches();
      if (m_digits.size() != 4) return 1'b0;
      for (int i = 0; i < 4; i++) if (m_digits[i] != m_code[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_step(bit v, int k, bit p, bit rn);
      mode_t prev;
      bit    acc;
      int    elapsed;
      if (!rn) begin
         m_mode = M_IDLE; m_digits.delete(); m_code = '{1, 2, 3, 4};
         m_fails = 0; m_quiet = 0;
         return;
      end
      prev    = m_mode;
      acc     = v && (m_mode != M_CHECK) && (m_mode != M_LOCKED);
      elapsed = m_quiet + 1;
      case (m_mode)
         M_IDLE: if (acc && k < 10) begin m_digits.push_back(k); m_mode = M_ENTRY; end
         M_ENTRY: begin
            if (acc) begin
               if (k < 10) begin if (m_digits.size() < 4) m_digits.push_back(k); end
               else if (k == 10) begin m_digits.delete(); m_mode = M_IDLE; end
               else if (k == 11) m_mode = M_CHECK;
            end else if (elapsed == ETO) begin
               m_digits.delete(); m_mode = M_IDLE;
            end
         end
         M_CHECK: begin
            if (code_matches()) begin
               m_fails = 0; m_mode = M_OPEN;
            end else begin
               if (m_fails < MAXF) m_fails++;
               m_mode = (m_fails == MAXF) ? M_LOCKED : M_IDLE;
            end
            m_digits.delete();
         end
         M_OPEN: begin
            if (acc) begin
               if (k == 11) m_mode = M_IDLE;
               else if (k == 10 && p) begin m_digits.delete(); m_mode = M_PROG; end
            end else if (elapsed == OTO) begin
               m_mode = M_IDLE;
            end
         end
         M_PROG: begin
            if (acc) begin
               if (k < 10) begin if (m_digits.size() < 4) m_digits.push_back(k); end
               else if (k == 10) m_digits.delete();
               else if (k == 11) begin
                  if (m_digits.size() == 4) for (int i = 0; i < 4; i++) m_code[i] = m_digits[i];
                  m_digits.delete(); m_mode = M_OPEN;
               end
            end else if (elapsed == OTO) begin
               m_digits.delete(); m_mode = M_IDLE;
            end
         end
         M_LOCKED: if (elapsed == LCK) begin m_fails = 0; m_mode = M_IDLE; end
         default: m_mode = M_IDLE;
      endcase
      m_quiet = (acc || m_mode != prev) ? 0 : elapsed;
   endfunction

   // {key_ready, lock, green, blue, lockout, fail_count}
   function automatic logic [6:0] model_outputs();
      logic [6:0] o;
      o[6]   = !(m_mode == M_CHECK || m_mode == M_LOCKED);
      o[5]   = !(m_mode == M_OPEN || m_mode == M_PROG);
      o[4]   = (m_mode == M_OPEN);
      o[3]   = (m_mode == M_ENTRY || m_mode == M_PROG);
      o[2]   = (m_mode == M_LOCKED);
      o[1:0] = 2'(m_fails);
      return o;
   endfunction

   task automatic drive(input bit v, input logic [3:0] k, input bit p, input bit rn);
      @(negedge clk);
      bus_if.key_valid = v;
      bus_if.key_code  = k;
      bus_if.prog_req  = p;
      rst_n            = rn;
      model_step(v, int'(k), p, rn);
      exp_q.push_back(model_outputs());
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 4'($urandom), 1'($urandom), 1'b1);
   endtask

   // Keys packed as nibbles, first key in the most significant used nibble.
   task automatic seq(input logic [31:0] s, input int n, input bit p = 1'b0);
      logic [31:0] t;
      for (int i = 0; i < n; i++) begin
         t = s >> (4 * (n - 1 - i));
         drive(1'b1, t[3:0], p, 1'b1);
         idle($urandom_range(2, 0));
      end
   endtask

   task automatic type_model_code();
      logic [31:0] s;
      s = {12'h000, 4'(m_code[0]), 4'(m_code[1]), 4'(m_code[2]), 4'(m_code[3]), 4'hB};
      seq(s, 5);
   endtask

   initial begin : monitor
      logic [6:0] exp_v;
      logic [6:0] act_v;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus_if.key_ready, bus_if.lock, bus_if.green, bus_if.blue,
                     bus_if.lockout, bus_if.fail_count};
            n_checks++;
            if (act_v !== exp_v) begin
               n_fail++;
               $display("FAIL outputs t=%0t {ready,lock,green,blue,lockout,fails} actual=%b required=%b",
                        $time, act_v, exp_v);
            end
         end
      end
   end

   initial begin : stimulus
      int r;
      bus_if.key_valid = 1'b0;
      bus_if.key_code  = 4'h0;
      bus_if.prog_req  = 1'b0;

      drive(1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      idle(2);

      // Correct code, then relock
      seq(32'h1234B, 5); idle(3); seq(32'hB, 1);

      // Three failures into lockout; correct code ignored while locked
      seq(32'h9999B, 5); seq(32'h9999B, 5); seq(32'h9999B, 5);
      seq(32'h1234B, 5); idle(70);
      seq(32'h1234B, 5); seq(32'hB, 1);

      // Short entry, CLEAR, over-long entry
      seq(32'h123B, 4); seq(32'h12A, 3); seq(32'h12345B, 6); seq(32'hB, 1);

      // Reprogram and use the new code
      seq(32'h1234B, 5); seq(32'hA, 1, 1'b1); seq(32'h7701B, 5); seq(32'hB, 1);
      seq(32'h1234B, 5); seq(32'h7701B, 5);
      seq(32'hA, 1, 1'b1); seq(32'h55B, 3); seq(32'hB, 1);
      seq(32'h7701B, 5); seq(32'hB, 1);

      // Timeouts: entry expiry, key on the expiry cycle, open and program expiry
      drive(1'b1, 4'h1, 1'b0, 1'b1); idle(ETO);
      drive(1'b1, 4'h1, 1'b0, 1'b1); idle(ETO - 1);
      drive(1'b1, 4'h2, 1'b0, 1'b1); idle(ETO + 2);
      seq(32'h7701B, 5); idle(OTO + 2);
      seq(32'h7701B, 5); seq(32'hA, 1, 1'b1); idle(OTO + 2);

      // Reset during entry, during lockout, and after reprogramming
      seq(32'h12, 2); drive(1'b0, 4'h0, 1'b0, 1'b0); idle(2);
      seq(32'h9B, 2); seq(32'h9B, 2); seq(32'h9B, 2); idle(5);
      drive(1'b0, 4'h0, 1'b0, 1'b0); idle(2);
      seq(32'h1234B, 5); seq(32'hA, 1, 1'b1); seq(32'h4321B, 5); seq(32'hB, 1);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      seq(32'h1234B, 5); seq(32'hB, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(99, 0);
         if (r < 30)      type_model_code();
         else if (r < 70) begin
            drive(1'b1, 4'($urandom), 1'($urandom), 1'b1);
            idle($urandom_range(3, 0));
         end
         else if (r < 82) idle($urandom_range(40, 0));
         else if (r < 85) drive(1'b0, 4'($urandom), 1'b0, 1'b0);
         else             seq(32'hA, 1, 1'b1);
      end

      idle(2);
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
